vga_frame_signature: RTL
========================

// Module: vga_frame_signature
// PURPOSE
//  Synthesizable frame checker on the VGA output path (after Interface_VGA). Samples
//  the pixel stream per Clock, folds every visible pixel into a 32-bit signature and
//  checks line/frame geometry. Gives an in-system golden-frame check without a file dump.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  V_ACTIVE  480  visible lines per frame
//  COLOR_W   8    bits per colour channel; 3*COLOR_W <= 32 (elaboration error otherwise)
//  SEED      32'hFFFF_FFFF  signature start value at each frame start
// PORTS
//  Clock       in   1        pixel clock (25 MHz domain); all logic on rising edge
//  Reset       in   1        asynchronous, active-low; clears all state
//  Start       in   1        1-cycle pulse; arms capture of the next full frame
//  Blank       in   1        data enable, 1 = visible pixel (VGA_BLANK_N semantics)
//  VSync       in   1        vertical sync, active-low
//  R,G,B       in   COLOR_W  pixel colour, valid when Blank=1
//  Busy        out  1        1 while state != IDLE
//  Signature   out  32       signature of last completed frame, held until next SigValid
//  SigValid    out  1        1-cycle pulse when Signature/FrameErr update
//  FrameErr    out  1        1 = geometry mismatch in reported frame
//  FrameCount  out  16       completed frames since reset, wraps FFFF->0000
// BEHAVIOUR
//  Reset: state IDLE; Signature=0, SigValid=0, FrameErr=0, FrameCount=0, Busy=0;
//   blank_q=0, vs_q=1; accumulators cleared. Reset mid-frame discards the frame.
//  Edges: vs_fall = vs_q & ~VSync; line_end = blank_q & ~Blank (vs_q/blank_q = prev sample).
//  FSM: IDLE -Start-> WAIT_VS -vs_fall-> CAPTURE -vs_fall-> DONE -> IDLE (1 cycle).
//   Start ignored when state != IDLE. Start and vs_fall same cycle: IDLE->WAIT_VS only.
//  On entering CAPTURE: sig=SEED, pix_cnt=0, line_cnt=0, err=0.
//  CAPTURE, each edge with Blank=1: sig <= {sig[30:0],sig[31]} ^ zero_ext({B,G,R});
//   pix_cnt++ (saturates at 2^$clog2(H_ACTIVE+1)-1).
//  CAPTURE, line_end: if pix_cnt != H_ACTIVE set err; line_cnt++ (saturating); pix_cnt=0.
//  Blank=1 on the vs_fall cycle: pixel is accumulated.
//  CAPTURE, vs_fall: frame closes; if line_cnt != V_ACTIVE or a line is still open
//   (blank_q=1) set err. Next cycle (DONE): Signature=sig, FrameErr=err,
//   SigValid=1, FrameCount++. Latency: SigValid 1 cycle after the vs_fall edge.
//  Frame with zero visible lines: FrameErr=1, Signature=SEED.
//  Outputs are registered; SigValid never asserted two consecutive cycles.
// CONFIGURATION
//  VGA_SIG_CONTINUOUS_EN defined: DONE -> CAPTURE (accumulators reseeded), so every
//   frame is reported back-to-back with no frame skipped; Busy stays 1; Start while
//   Busy still ignored.
//  Not defined: single-shot; DONE -> IDLE, one report per Start.
// TESTING (H_ACTIVE=4, V_ACTIVE=2, COLOR_W=8 unless stated)
//  Reset low mid-CAPTURE -> all outputs 0, Busy=0 same cycle (async); no SigValid after release.
//  Start, 2 vsyncs, 2 lines x 4 pixels all 0 -> one SigValid, Signature=FFFFFFFF, FrameErr=0,
//   FrameCount=1.
//  Same, first pixel {B,G,R}=24'h000001, rest 0 -> Signature=FFFFFF7F, FrameErr=0.
//  Second line only 3 pixels -> SigValid with FrameErr=1; third line added (3 lines) -> FrameErr=1.
//  Start pulsed again while Busy -> ignored: exactly one SigValid, then Busy=0 (single-shot).
//  VGA_SIG_CONTINUOUS_EN, 3 black frames -> 3 SigValid pulses, each FFFFFFFF, FrameCount 1,2,3.

Source files
------------

// File: rtl/vga_frame_signature_if.sv
// Pixel-stream and frame-report bundle for vga_frame_signature.
// master: the video source / host side; slave: the signature checker.
interface vga_frame_signature_if #(
   parameter int COLOR_W = 8
);
   logic               Start;
   logic               Blank;
   logic               VSync;
   logic [COLOR_W-1:0] R;
   logic [COLOR_W-1:0] G;
   logic [COLOR_W-1:0] B;
   logic               Busy;
   logic [31:0]        Signature;
   logic               SigValid;
   logic               FrameErr;
   logic [15:0]        FrameCount;

   modport master (
      output Start, Blank, VSync, R, G, B,
      input  Busy, Signature, SigValid, FrameErr, FrameCount
   );

   modport slave (
      input  Start, Blank, VSync, R, G, B,
      output Busy, Signature, SigValid, FrameErr, FrameCount
   );
endinterface

// File: rtl/vga_frame_signature.sv
// In-system frame checker on the VGA output path. Every visible pixel of an
// armed frame is folded into a 32-bit rotate/XOR signature, and the line and
// frame geometry are checked against H_ACTIVE x V_ACTIVE.
// Optional build macro VGA_SIG_CONTINUOUS_EN: when defined, every frame is
// reported back to back after a single Start; otherwise one report per Start.
module vga_frame_signature #(
   parameter int          H_ACTIVE = 640,
   parameter int          V_ACTIVE = 480,
   parameter int          COLOR_W  = 8,
   parameter logic [31:0] SEED     = 32'hFFFF_FFFF
) (
   input logic                  Clock,
   input logic                  Reset,
   vga_frame_signature_if.slave bus
);

   // Counters are just wide enough to hold the nominal value; they saturate
   // so an over-long line or frame can never wrap back onto a "good" count.
   localparam int PIX_W  = $clog2(H_ACTIVE + 1);
   localparam int LINE_W = $clog2(V_ACTIVE + 1);

   generate
      if (3 * COLOR_W > 32) begin : g_color_w_check
         $error("vga_frame_signature: 3*COLOR_W must not exceed 32");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state;
   logic                blank_q;
   logic                vs_q;
   logic                vs_fall;
   logic                line_end;
   logic [31:0]         pixel_word;
   logic [31:0]         sig;
   logic [PIX_W-1:0]    pix_cnt;
   logic [LINE_W-1:0]   line_cnt;
   logic                err;
   logic                busy;
   logic [31:0]         signature;
   logic                sig_valid;
   logic                frame_err;
   logic [15:0]         frame_count;

   // One signature step: rotate left by one, then mix in the pixel.
   function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] w);
      return {s[30:0], s[31]} ^ w;
   endfunction

   // Saturating increment of the pixel-per-line counter.
   function automatic logic [PIX_W-1:0] pix_inc(input logic [PIX_W-1:0] c);
      return (c == {PIX_W{1'b1}}) ? c : c + PIX_W'(1);
   endfunction

   // Saturating increment of the line-per-frame counter.
   function automatic logic [LINE_W-1:0] line_inc(input logic [LINE_W-1:0] c);
      return (c == {LINE_W{1'b1}}) ? c : c + LINE_W'(1);
   endfunction

   // {B,G,R} zero-extended to the signature width.
   assign pixel_word = 32'({bus.B, bus.G, bus.R});

   // Edge detection against the previous sample of the sync/enable inputs.
   assign vs_fall  = vs_q & ~bus.VSync;
   assign line_end = blank_q & ~bus.Blank;

   // Previous-sample registers for VSync and Blank; idle levels after reset.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         blank_q <= 1'b0;
         vs_q    <= 1'b1;
      end else begin
         blank_q <= bus.Blank;
         vs_q    <= bus.VSync;
      end
   end

   // Arm / capture / report sequencer with accumulators and registered outputs.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         sig         <= '0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         err         <= 1'b0;
         busy        <= 1'b0;
         signature   <= '0;
         sig_valid   <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
      end else begin
         sig_valid <= 1'b0;
         case (state)
            IDLE: begin
               // A vsync edge coinciding with Start only arms; the frame that
               // is already under way is never captured partially.
               if (bus.Start) begin
                  state <= WAIT_VS;
                  busy  <= 1'b1;
               end
            end

            WAIT_VS: begin
               if (vs_fall) begin
                  state    <= CAPTURE;
                  sig      <= SEED;
                  pix_cnt  <= '0;
                  line_cnt <= '0;
                  err      <= 1'b0;
               end
            end

            CAPTURE: begin
               if (bus.Blank) begin
                  sig     <= fold(sig, pixel_word);
                  pix_cnt <= pix_inc(pix_cnt);
               end
               if (line_end) begin
                  if (pix_cnt != PIX_W'(H_ACTIVE)) begin
                     err <= 1'b1;
                  end
                  line_cnt <= line_inc(line_cnt);
                  pix_cnt  <= '0;
               end
               // Closing edge: a visible pixel on this edge is still folded
               // in above; a line still open here is a truncated line.
               if (vs_fall) begin
                  if ((line_cnt != LINE_W'(V_ACTIVE)) || blank_q) begin
                     err <= 1'b1;
                  end
                  state <= DONE;
               end
            end

            DONE: begin
               signature   <= sig;
               frame_err   <= err;
               sig_valid   <= 1'b1;
               frame_count <= frame_count + 16'd1;
`ifdef VGA_SIG_CONTINUOUS_EN
               // Reseed immediately so the frame that has just begun is the
               // next one reported; nothing is skipped between reports.
               state    <= CAPTURE;
               sig      <= SEED;
               pix_cnt  <= '0;
               line_cnt <= '0;
               err      <= 1'b0;
`else
               state <= IDLE;
               busy  <= 1'b0;
`endif
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy       = busy;
   assign bus.Signature  = signature;
   assign bus.SigValid   = sig_valid;
   assign bus.FrameErr   = frame_err;
   assign bus.FrameCount = frame_count;

endmodule
